// File: rtl/ex15_consensus.sv
// Consensus-theorem block: F = A·B | ~A·C, with a registered copy, an F-high
// cycle counter and a sticky flag comparing against the three-term form.
module ex15_consensus #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             en,
    input  logic             clr,
    output logic             F,
    output logic [2:0]       terms,
    output logic             F_q,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             cons_err
);

    logic             f_full;
    logic             fq_q, fq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign terms  = {A & B, ~A & C, B & C};
    assign F      = terms[2] | terms[1];
    // B·C is redundant, so f_full must always equal F; err flags a broken gate
    assign f_full = terms[2] | terms[1] | terms[0];

    always_comb begin
        fq_d  = fq_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (en) fq_d = F;
        if (clr) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (en) begin
            if (F && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
            if (F != f_full) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq_q  <= 1'b0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            fq_q  <= fq_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign F_q      = fq_q;
    assign hit_cnt  = cnt_q;
    assign cons_err = err_q;

endmodule

// File: tb/tb_ex15_consensus.sv
// Directed bench for ex15_consensus with CNT_W=2 so saturation is reachable.
module tb_ex15_consensus;
    localparam int CNT_W = 2;

    logic             clk, rst_n, A, B, C, en, clr;
    logic             F, F_q, cons_err;
    logic [2:0]       terms;
    logic [CNT_W-1:0] hit_cnt;

    int total = 0;
    int bad   = 0;

    ex15_consensus #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .en(en), .clr(clr),
        .F(F), .terms(terms), .F_q(F_q), .hit_cnt(hit_cnt), .cons_err(cons_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_abc(input logic [2:0] v);
        {A, B, C} = v;
        #1;
    endtask

    // inputs change 1ns after the rising edge, far from the next one
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] tt;
    logic [2:0] tterm [8];
    int         exp_hit;

    initial begin
        tt    = 8'b1100_1010;
        tterm = '{3'b000, 3'b010, 3'b000, 3'b011, 3'b000, 3'b000, 3'b100, 3'b101};
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; {A, B, C} = 3'b000;
        #2;
        chk("rst_fq", 32'(F_q), 0);
        chk("rst_hit", 32'(hit_cnt), 0);
        chk("rst_err", 32'(cons_err), 0);

        set_abc(3'b110); chk("comb_110", 32'(F), 1);
        set_abc(3'b001); chk("comb_001", 32'(F), 1);
        set_abc(3'b000); chk("comb_000", 32'(F), 0);
        set_abc(3'b011); chk("comb_011", 32'(F), 1);
        chk("terms_011", 32'(terms), 32'h3);

        tick;
        rst_n = 1'b1;
        en    = 1'b1;
        exp_hit = 0;
        for (int i = 0; i < 8; i++) begin
            set_abc(3'(i));
            chk($sformatf("sw_F%0d", i), 32'(F), 32'(tt[i]));
            chk($sformatf("sw_terms%0d", i), 32'(terms), 32'(tterm[i]));
            tick;
            if (tt[i] && exp_hit < 3) exp_hit++;
            chk($sformatf("sw_Fq%0d", i), 32'(F_q), 32'(tt[i]));
            chk($sformatf("sw_hit%0d", i), 32'(hit_cnt), 32'(exp_hit));
        end
        chk("sw_err", 32'(cons_err), 0);

        set_abc(3'b111);
        clr = 1'b1;
        tick;
        chk("clr_pre_hit", 32'(hit_cnt), 0);
        chk("clr_pre_fq", 32'(F_q), 1);
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk($sformatf("sat_%0d", i), 32'(hit_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        clr = 1'b1;
        tick;
        chk("clr_hit", 32'(hit_cnt), 0);
        chk("clr_err", 32'(cons_err), 0);
        clr = 1'b0;

        set_abc(3'b110);
        tick;
        chk("reg_fq1", 32'(F_q), 1);
        set_abc(3'b000);
        tick;
        chk("reg_fq0", 32'(F_q), 0);
        chk("reg_hit", 32'(hit_cnt), 1);

        en = 1'b0;
        set_abc(3'b111); chk("gate_F111", 32'(F), 1); tick;
        set_abc(3'b001); chk("gate_F001", 32'(F), 1); tick;
        set_abc(3'b100); chk("gate_F100", 32'(F), 0); tick;
        set_abc(3'b110); chk("gate_F110", 32'(F), 1); tick;
        chk("gate_fq", 32'(F_q), 0);
        chk("gate_hit", 32'(hit_cnt), 1);
        chk("gate_err", 32'(cons_err), 0);

        en = 1'b1;
        set_abc(3'b111);
        tick;
        chk("pre_rst_fq", 32'(F_q), 1);
        chk("pre_rst_hit", 32'(hit_cnt), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_fq", 32'(F_q), 0);
        chk("mid_rst_hit", 32'(hit_cnt), 0);
        chk("mid_rst_err", 32'(cons_err), 0);
        chk("mid_rst_F", 32'(F), 1);
        set_abc(3'b010);
        chk("mid_rst_F010", 32'(F), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex15_consensus.md
# ex15_consensus

Combinational consensus-theorem logic block computing F = A·B + A'·C, the simplified form of A·B + A'·C + B·C with the redundant consensus term B·C eliminated. It is a leaf in the digital-logic exercise set. A registered side path adds a latched copy of F, an activity counter and a sticky self-check flag that compares the simplified form against the unsimplified three-term form. The combinational output F never depends on clock or reset.

## Interface
Parameters:
- CNT_W, 8, width of the F-high cycle counter (min 1).

Ports:
- clk  input  1  single clock; all registers update on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  1  logic input A.
- B  input  1  logic input B.
- C  input  1  logic input C.
- en  input  1  enables the registered path (F_q, hit_cnt, cons_err update).
- clr  input  1  synchronous clear of hit_cnt and cons_err.
- F  output  1  combinational result A·B | ~A·C.
- terms  output  3  combinational product terms {A·B, ~A·C, B·C}; bit 2 = A·B, bit 1 = ~A·C, bit 0 = B·C.
- F_q  output  1  registered F.
- hit_cnt  output  CNT_W  saturating count of enabled cycles with F=1.
- cons_err  output  1  sticky flag: simplified and unsimplified forms disagreed.

## Operation
- F = (A & B) | (~A & C); purely combinational; valid within one delta of any A/B/C change, regardless of clk, rst_n, en, clr (including while they are undriven or held in reset).
- Truth table for F (ABC -> F): 000->0, 001->1, 010->0, 011->1, 100->0, 101->0, 110->1, 111->1.
- B·C is redundant: whenever B=C=1, either A=1 (A·B=1) or A=0 (~A·C=1), so F equals the three-term form for all inputs.
- F_full = A·B | ~A·C | B·C, internal only.
- Registered path, on rising clk when rst_n=1:
  - clr=1: hit_cnt <= 0; cons_err <= 0; F_q still loads F if en=1. clr has priority over en for hit_cnt and cons_err.
  - en=1, clr=0: F_q <= F. If F=1, hit_cnt increments, saturating at 2^CNT_W-1 (no wrap). If F != F_full, cons_err <= 1 (sticky).
  - en=0, clr=0: all registers hold.
- cons_err is an in-silicon check; a correct implementation never sets it. It exists for fault and mutation testing.

## Timing
- F and terms: zero-cycle combinational latency.
- F_q: one-cycle latency from A/B/C sampled at a rising edge with en=1.
- hit_cnt and cons_err reflect inputs sampled at the previous enabled edge.
- Reset values (rst_n=0, asynchronous, immediate): F_q=0, hit_cnt=0, cons_err=0. F and terms are unaffected by reset.
- Reset deassertion is treated as synchronous to clk by the integrator. The first update occurs on the first rising edge with rst_n=1.
- Reset asserted mid-count clears hit_cnt at once, with no wait for a clock edge.

## Test plan
- Combinational, no clock: ABC=110 -> F=1 (A·B); 001 -> F=1 (~A·C); 000 -> F=0; 011 -> F=1, terms=3'b011 (B·C redundancy).
- Exhaustive sweep of all 8 ABC combinations -> F matches the truth table; F equals the three-term form; cons_err stays 0 with en=1.
- Reset: assert rst_n=0 between edges -> F_q, hit_cnt, cons_err go 0 immediately, while F still tracks ABC (e.g. 111 -> F=1).
- Registered path: en=1, apply 110 then 000 on consecutive edges -> F_q reads 1 then 0 with one-cycle lag; hit_cnt=1.
- Saturation with CNT_W=2: hold ABC=111, en=1 for 6 edges -> hit_cnt counts 1,2,3,3,3,3. Then clr=1 for one edge -> hit_cnt=0.
- Enable gating: en=0, toggle ABC over 4 edges -> F_q, hit_cnt, cons_err unchanged, while F follows the inputs.
